vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- H_VISIBLE, 640, active pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_VISIBLE, 480, active lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
REQ-002 vga_clk  input  1  pixel clock, single clock domain, rising edge only.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 pix_en  input  1  pixel advance enable; counters advance only when high.
REQ-005 DrawX  output  10  current pixel column, 0..H_TOTAL-1.
REQ-006 DrawY  output  10  current line, 0..V_TOTAL-1.
REQ-007 hs  output  1  horizontal sync, active low.
REQ-008 vs  output  1  vertical sync, active low.
REQ-009 blank  output  1  display-enable, HIGH when (DrawX,DrawY) is visible, LOW in porches/sync.
REQ-010 frame_end  output  1  one-cycle pulse on the last pixel of a frame.
REQ-011 frame_count  output  8  completed-frame counter, wraps.

Function
REQ-012 H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP (525).
REQ-013 When pix_en=1, DrawX increments by 1 per clock. DrawX = H_TOTAL-1 wraps to 0 and advances DrawY by 1.
REQ-014 DrawY = V_TOTAL-1 at the DrawX wrap goes to 0, and frame_count increments by 1. frame_count 255 wraps to 0.
REQ-015 When pix_en=0, DrawX, DrawY, hs, vs, blank and frame_count hold their values.
REQ-016 hs = 0 iff H_VISIBLE+H_FP <= DrawX < H_VISIBLE+H_FP+H_SYNC (656..751).
REQ-017 vs = 0 iff V_VISIBLE+V_FP <= DrawY < V_VISIBLE+V_FP+V_SYNC (490..491).
REQ-018 blank = 1 iff DrawX < H_VISIBLE and DrawY < V_VISIBLE.
REQ-019 hs, vs and blank are flops, not a combinational decode of DrawX/DrawY.
- Their inputs are computed from the next counter state.
- Each cycle, they are exactly consistent with the DrawX/DrawY presented in that same cycle (zero skew).
REQ-020 frame_end = pix_en AND (DrawX = H_TOTAL-1) AND (DrawY = V_TOTAL-1).
- It is the only combinational output.
- It is forced 0 while reset = 1.
REQ-021 All counter arithmetic is unsigned at 10 bits. Defaults never exceed 1023; parameter sets whose totals exceed 1024 are unsupported.

Reset
REQ-022 On a clock edge with reset=1, outputs take these values regardless of pix_en:
- DrawX = 0, DrawY = 0
- hs = 1, vs = 1, blank = 1 (consistent with position 0,0)
- frame_count = 0
REQ-023 Reset asserted mid-frame (any DrawX/DrawY) takes effect at the next edge, with no partial-line completion.
REQ-024 On the first edge with reset=0 and pix_en=1, DrawX becomes 1.

Structure
REQ-025 H_/V_ default timing constants, H_TOTAL, V_TOTAL and the 10-bit coordinate typedef live in shared package vga_pkg, for use by sprite/ROM address consumers.
REQ-026 Single module, no sub-module. Horizontal and vertical counters are separate always_ff processes, or a single one.

Verification
REQ-027 Reset, then pix_en=1 for 800 clocks -> DrawX sequence 0..799 then 0; DrawY 0 then 1; blank high for exactly 640 clocks.
REQ-028 Run one line -> hs low for exactly 96 clocks, first low at DrawX=656, high again at DrawX=752; blank=0 throughout hs low.
REQ-029 Run a full frame of 420000 clocks -> vs low for exactly 1600 clocks (DrawY 490..491); frame_end pulses once at (799,524); frame_count 0->1; next state (0,0) with blank=1.
REQ-030 Toggle pix_en low for 5 clocks at DrawX=639, DrawY=479 -> all outputs hold, frame_end=0; resume -> DrawX=640, blank=0.
REQ-031 Assert reset for 1 clock at DrawX=700, DrawY=300 -> next cycle shows DrawX=0, DrawY=0, hs=1, vs=1, blank=1, frame_count=0.
REQ-032 Run 256 frames -> frame_count wraps 255->0; frame_end count = 256.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing constants and coordinate type for the timing generator and
// for downstream sprite/ROM address logic that consumes DrawX/DrawY.
package vga_pkg;

  localparam int unsigned COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;

  // 640x480 @ 60 Hz industry timing
  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned H_FP      = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BP      = 48;
  localparam int unsigned H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_FP      = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BP      = 33;
  localparam int unsigned V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

  // Half-open window test lo <= v < hi, shared by the sync and blank decodes.
  function automatic logic in_window(input coord_t v, input coord_t lo, input coord_t hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters with registered, zero-skew
// sync and display-enable outputs plus a frame-end strobe and frame counter.
module vga_timing_gen
  import vga_pkg::coord_t;
  import vga_pkg::in_window;
#(
  parameter int unsigned H_VISIBLE = vga_pkg::H_VISIBLE,
  parameter int unsigned H_FP      = vga_pkg::H_FP,
  parameter int unsigned H_SYNC    = vga_pkg::H_SYNC,
  parameter int unsigned H_BP      = vga_pkg::H_BP,
  parameter int unsigned V_VISIBLE = vga_pkg::V_VISIBLE,
  parameter int unsigned V_FP      = vga_pkg::V_FP,
  parameter int unsigned V_SYNC    = vga_pkg::V_SYNC,
  parameter int unsigned V_BP      = vga_pkg::V_BP
) (
  input  logic       vga_clk,
  input  logic       reset,
  input  logic       pix_en,
  output coord_t     DrawX,
  output coord_t     DrawY,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic       frame_end,
  output logic [7:0] frame_count
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam coord_t H_LAST     = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST     = coord_t'(V_TOTAL - 1);
  localparam coord_t H_ACT_END  = coord_t'(H_VISIBLE);
  localparam coord_t V_ACT_END  = coord_t'(V_VISIBLE);
  localparam coord_t HS_START   = coord_t'(H_VISIBLE + H_FP);
  localparam coord_t HS_END     = coord_t'(H_VISIBLE + H_FP + H_SYNC);
  localparam coord_t VS_START   = coord_t'(V_VISIBLE + V_FP);
  localparam coord_t VS_END     = coord_t'(V_VISIBLE + V_FP + V_SYNC);

  coord_t x_next;
  coord_t y_next;
  logic   x_last;
  logic   y_last;

  assign x_last = (DrawX == H_LAST);
  assign y_last = (DrawY == V_LAST);

  // NOTE: every always_comb output gets a default first so no path can leave it
  // unassigned; an incomplete if/else here would infer a latch.
  always_comb begin
    x_next = DrawX;
    y_next = DrawY;
    if (pix_en) begin
      if (x_last) begin
        x_next = '0;
        y_next = y_last ? '0 : DrawY + 1'b1;
      end else begin
        x_next = DrawX + 1'b1;
      end
    end
  end

  assign frame_end = !reset && pix_en && x_last && y_last;

  // Sync and blank are decoded from the next position, so they leave the flops
  // on the same edge as the coordinates they describe.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      DrawX       <= '0;
      DrawY       <= '0;
      hs          <= 1'b1;
      vs          <= 1'b1;
      blank       <= 1'b1;
      frame_count <= '0;
    end else begin
      DrawX <= x_next;
      DrawY <= y_next;
      hs    <= !in_window(x_next, HS_START, HS_END);
      vs    <= !in_window(y_next, VS_START, VS_END);
      blank <= (x_next < H_ACT_END) && (y_next < V_ACT_END);
      if (frame_end) begin
        frame_count <= frame_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: a small-timing instance and a default-timing instance
// share stimulus and are compared against a position-from-step-count model.
module tb_vga_timing_gen;

  typedef logic [9:0] coord_t;

  typedef struct {
    int hv, hf, hs, hb, vv, vf, vs, vb;
  } tim_t;

  typedef struct {
    coord_t     x;
    coord_t     y;
    logic [7:0] fc;
    logic       hs;
    logic       vs;
    logic       blank;
    logic       fe;
  } exp_t;

  localparam int S_HV = 8, S_HF = 2, S_HS = 3, S_HB = 2;
  localparam int S_VV = 6, S_VF = 1, S_VS = 2, S_VB = 2;
  localparam int S_HT = S_HV + S_HF + S_HS + S_HB;   // 15
  localparam int S_VT = S_VV + S_VF + S_VS + S_VB;   // 11
  localparam int S_FRAME = S_HT * S_VT;              // 165

  tim_t ts = '{S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB};
  tim_t td = '{640, 16, 96, 48, 480, 10, 2, 33};

  logic       vga_clk = 1'b0;
  logic       reset = 1'b1;
  logic       pix_en = 1'b0;

  coord_t     sx, sy, dx, dy;
  logic       s_hs, s_vs, s_blank, s_fe;
  logic       d_hs, d_vs, d_blank, d_fe;
  logic [7:0] s_fc, d_fc;

  int n = 0;       // enabled edges since the last reset edge
  int checks = 0;
  int fails = 0;

  always #5 vga_clk = ~vga_clk;

  vga_timing_gen #(
    .H_VISIBLE(S_HV), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
    .V_VISIBLE(S_VV), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB)
  ) dut_small (
    .vga_clk(vga_clk), .reset(reset), .pix_en(pix_en),
    .DrawX(sx), .DrawY(sy), .hs(s_hs), .vs(s_vs), .blank(s_blank),
    .frame_end(s_fe), .frame_count(s_fc)
  );

  vga_timing_gen dut_def (
    .vga_clk(vga_clk), .reset(reset), .pix_en(pix_en),
    .DrawX(dx), .DrawY(dy), .hs(d_hs), .vs(d_vs), .blank(d_blank),
    .frame_end(d_fe), .frame_count(d_fc)
  );

  // Expected outputs after `steps` enabled edges, straight from the raster rules.
  function automatic exp_t model(input int steps, input tim_t t, input logic r, input logic en);
    exp_t e;
    int ht, vt, pos, x, y;
    ht  = t.hv + t.hf + t.hs + t.hb;
    vt  = t.vv + t.vf + t.vs + t.vb;
    pos = steps % (ht * vt);
    x   = pos % ht;
    y   = pos / ht;
    e.x     = coord_t'(x);
    e.y     = coord_t'(y);
    e.fc    = 8'((steps / (ht * vt)) % 256);
    e.hs    = !(x >= t.hv + t.hf && x < t.hv + t.hf + t.hs);
    e.vs    = !(y >= t.vv + t.vf && y < t.vv + t.vf + t.vs);
    e.blank = (x < t.hv) && (y < t.vv);
    e.fe    = !r && en && (x == ht - 1) && (y == vt - 1);
    return e;
  endfunction

  task automatic set_in(input logic r, input logic en);
    reset  = r;
    pix_en = en;
    #1;
  endtask

  task automatic tick();
    @(posedge vga_clk);
    if (reset) n = 0;
    else if (pix_en) n++;
    #1;
  endtask

  task automatic do_reset();
    set_in(1'b1, 1'b0);
    tick();
  endtask

  task automatic advance(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      set_in(1'b0, 1'b1);
      tick();
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 1'($urandom_range(0, 1)));
      tick();
    end
    set_in(1'b1, 1'b1);
    checks += 8;
    if (sx !== 10'd0 || sy !== 10'd0) begin fails++; $display("FAIL reset_small_xy: got (%0d,%0d), expected (0,0)", sx, sy); end
    if (dx !== 10'd0 || dy !== 10'd0) begin fails++; $display("FAIL reset_def_xy: got (%0d,%0d), expected (0,0)", dx, dy); end
    if ({s_hs, s_vs, s_blank} !== 3'b111) begin fails++; $display("FAIL reset_small_sync: got hs/vs/blank=%b, expected 111", {s_hs, s_vs, s_blank}); end
    if ({d_hs, d_vs, d_blank} !== 3'b111) begin fails++; $display("FAIL reset_def_sync: got hs/vs/blank=%b, expected 111", {d_hs, d_vs, d_blank}); end
    if (s_fc !== 8'd0) begin fails++; $display("FAIL reset_small_fc: got %0d, expected 0", s_fc); end
    if (d_fc !== 8'd0) begin fails++; $display("FAIL reset_def_fc: got %0d, expected 0", d_fc); end
    if (s_fe !== 1'b0) begin fails++; $display("FAIL reset_small_fe: got %b, expected 0", s_fe); end
    if (d_fe !== 1'b0) begin fails++; $display("FAIL reset_def_fe: got %b, expected 0", d_fe); end
    set_in(1'b0, 1'b1);
    tick();
    checks += 2;
    if (sx !== 10'd1) begin fails++; $display("FAIL first_step_small: got DrawX=%0d, expected 1", sx); end
    if (dx !== 10'd1) begin fails++; $display("FAIL first_step_def: got DrawX=%0d, expected 1", dx); end
  endtask

  task automatic test_line_default();
    int blank_cnt = 0, hs_low = 0, first_low = -1, rise_x = -1, blank_in_hs = 0;
    logic prev_hs = 1'b1;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      set_in(1'b0, 1'b1);
      checks++;
      if (dx !== coord_t'(i) || dy !== 10'd0) begin
        fails++; $display("FAIL line_seq: got (%0d,%0d), expected (%0d,0)", dx, dy, i);
      end
      if (d_blank === 1'b1) blank_cnt++;
      if (d_hs === 1'b0) begin
        hs_low++;
        if (first_low < 0) first_low = int'(dx);
        if (d_blank !== 1'b0) blank_in_hs++;
      end
      if (prev_hs === 1'b0 && d_hs === 1'b1 && rise_x < 0) rise_x = int'(dx);
      prev_hs = d_hs;
      tick();
    end
    checks += 6;
    if (dx !== 10'd0 || dy !== 10'd1) begin fails++; $display("FAIL line_wrap: got (%0d,%0d), expected (0,1)", dx, dy); end
    if (blank_cnt != 640) begin fails++; $display("FAIL line_blank_cnt: got %0d, expected 640", blank_cnt); end
    if (hs_low != 96) begin fails++; $display("FAIL line_hs_low: got %0d, expected 96", hs_low); end
    if (first_low != 656) begin fails++; $display("FAIL line_hs_first: got %0d, expected 656", first_low); end
    if (rise_x != 752) begin fails++; $display("FAIL line_hs_rise: got %0d, expected 752", rise_x); end
    if (blank_in_hs != 0) begin fails++; $display("FAIL line_blank_in_hs: got %0d, expected 0", blank_in_hs); end
  endtask

  task automatic test_frame_small();
    int vs_low = 0, fe_cnt = 0, fe_x = -1, fe_y = -1;
    do_reset();
    for (int i = 0; i < S_FRAME; i++) begin
      set_in(1'b0, 1'b1);
      if (s_vs === 1'b0) vs_low++;
      if (s_fe === 1'b1) begin fe_cnt++; fe_x = int'(sx); fe_y = int'(sy); end
      if (i == S_FRAME - 1) begin
        checks++;
        if (s_fc !== 8'd0) begin fails++; $display("FAIL frame_fc_before: got %0d, expected 0", s_fc); end
      end
      tick();
    end
    checks += 6;
    if (vs_low != S_HT * S_VS) begin fails++; $display("FAIL frame_vs_low: got %0d, expected %0d", vs_low, S_HT * S_VS); end
    if (fe_cnt != 1) begin fails++; $display("FAIL frame_fe_cnt: got %0d, expected 1", fe_cnt); end
    if (fe_x != S_HT - 1 || fe_y != S_VT - 1) begin fails++; $display("FAIL frame_fe_pos: got (%0d,%0d), expected (%0d,%0d)", fe_x, fe_y, S_HT - 1, S_VT - 1); end
    if (s_fc !== 8'd1) begin fails++; $display("FAIL frame_fc_after: got %0d, expected 1", s_fc); end
    if (sx !== 10'd0 || sy !== 10'd0) begin fails++; $display("FAIL frame_next_pos: got (%0d,%0d), expected (0,0)", sx, sy); end
    if (s_blank !== 1'b1) begin fails++; $display("FAIL frame_next_blank: got %b, expected 1", s_blank); end
  endtask

  task automatic test_pause();
    logic [3:0] snap;
    do_reset();
    advance((S_VV - 1) * S_HT + S_HV - 1);
    snap = {s_hs, s_vs, s_blank, 1'b0};
    for (int i = 0; i < 5; i++) begin
      set_in(1'b0, 1'b0);
      checks += 4;
      if (sx !== coord_t'(S_HV - 1) || sy !== coord_t'(S_VV - 1)) begin
        fails++; $display("FAIL pause_pos: got (%0d,%0d), expected (%0d,%0d)", sx, sy, S_HV - 1, S_VV - 1);
      end
      if ({s_hs, s_vs, s_blank, 1'b0} !== snap || s_blank !== 1'b1) begin
        fails++; $display("FAIL pause_sync: got hs/vs/blank=%b, expected %b with blank=1", {s_hs, s_vs, s_blank}, snap[3:1]);
      end
      if (s_fc !== 8'd0) begin fails++; $display("FAIL pause_fc: got %0d, expected 0", s_fc); end
      if (s_fe !== 1'b0) begin fails++; $display("FAIL pause_fe: got %b, expected 0", s_fe); end
      tick();
    end
    set_in(1'b0, 1'b1);
    tick();
    checks += 2;
    if (sx !== coord_t'(S_HV)) begin fails++; $display("FAIL resume_x: got %0d, expected %0d", sx, S_HV); end
    if (s_blank !== 1'b0) begin fails++; $display("FAIL resume_blank: got %b, expected 0", s_blank); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    advance(7 * S_HT + 12);   // inside both sync pulses of the small raster
    set_in(1'b1, 1'b1);
    checks++;
    if (s_hs !== 1'b0 || s_vs !== 1'b0) begin fails++; $display("FAIL mid_pre_sync: got hs/vs=%b%b, expected 00", s_hs, s_vs); end
    tick();
    checks += 3;
    if (sx !== 10'd0 || sy !== 10'd0) begin fails++; $display("FAIL mid_reset_pos: got (%0d,%0d), expected (0,0)", sx, sy); end
    if ({s_hs, s_vs, s_blank} !== 3'b111) begin fails++; $display("FAIL mid_reset_sync: got %b, expected 111", {s_hs, s_vs, s_blank}); end
    if (s_fc !== 8'd0) begin fails++; $display("FAIL mid_reset_fc: got %0d, expected 0", s_fc); end
    // frame_end gating at the last pixel of the frame
    advance(S_FRAME - 1);
    set_in(1'b0, 1'b0);
    checks++;
    if (s_fe !== 1'b0) begin fails++; $display("FAIL fe_gate_en: got %b, expected 0", s_fe); end
    set_in(1'b0, 1'b1);
    checks++;
    if (s_fe !== 1'b1) begin fails++; $display("FAIL fe_last_pixel: got %b, expected 1", s_fe); end
    set_in(1'b1, 1'b1);
    checks++;
    if (s_fe !== 1'b0) begin fails++; $display("FAIL fe_gate_reset: got %b, expected 0", s_fe); end
    tick();
    checks++;
    if (sx !== 10'd0 || sy !== 10'd0 || s_fc !== 8'd0) begin
      fails++; $display("FAIL fe_reset_state: got (%0d,%0d) fc=%0d, expected (0,0) fc=0", sx, sy, s_fc);
    end
  endtask

  task automatic test_random();
    exp_t es, ed;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      set_in(1'($urandom_range(0, 499) == 0), 1'($urandom_range(0, 3) != 0));
      es = model(n, ts, reset, pix_en);
      ed = model(n, td, reset, pix_en);
      checks += 6;
      if (sx !== es.x || sy !== es.y) begin fails++; $display("FAIL rnd_small_pos n=%0d: got (%0d,%0d), expected (%0d,%0d)", n, sx, sy, es.x, es.y); end
      if ({s_hs, s_vs, s_blank} !== {es.hs, es.vs, es.blank}) begin fails++; $display("FAIL rnd_small_sync n=%0d: got %b, expected %b", n, {s_hs, s_vs, s_blank}, {es.hs, es.vs, es.blank}); end
      if (s_fc !== es.fc || s_fe !== es.fe) begin fails++; $display("FAIL rnd_small_frame n=%0d: got fc=%0d fe=%b, expected fc=%0d fe=%b", n, s_fc, s_fe, es.fc, es.fe); end
      if (dx !== ed.x || dy !== ed.y) begin fails++; $display("FAIL rnd_def_pos n=%0d: got (%0d,%0d), expected (%0d,%0d)", n, dx, dy, ed.x, ed.y); end
      if ({d_hs, d_vs, d_blank} !== {ed.hs, ed.vs, ed.blank}) begin fails++; $display("FAIL rnd_def_sync n=%0d: got %b, expected %b", n, {d_hs, d_vs, d_blank}, {ed.hs, ed.vs, ed.blank}); end
      if (d_fc !== ed.fc || d_fe !== ed.fe) begin fails++; $display("FAIL rnd_def_frame n=%0d: got fc=%0d fe=%b, expected fc=%0d fe=%b", n, d_fc, d_fe, ed.fc, ed.fe); end
      tick();
    end
  endtask

  task automatic test_wrap();
    int fe_cnt = 0;
    bit wrap_seen = 0;
    logic [7:0] prev_fc;
    exp_t es;
    do_reset();
    prev_fc = s_fc;
    for (int i = 0; i < 256 * S_FRAME; i++) begin
      set_in(1'b0, 1'b1);
      if (s_fe === 1'b1) begin
        fe_cnt++;
        es = model(n, ts, reset, pix_en);
        checks++;
        if (s_fc !== es.fc) begin fails++; $display("FAIL wrap_fc_at_end: got %0d, expected %0d", s_fc, es.fc); end
      end
      if (prev_fc === 8'd255 && s_fc === 8'd0) wrap_seen = 1;
      prev_fc = s_fc;
      tick();
    end
    if (prev_fc === 8'd255 && s_fc === 8'd0) wrap_seen = 1;
    checks += 3;
    if (fe_cnt != 256) begin fails++; $display("FAIL wrap_fe_cnt: got %0d, expected 256", fe_cnt); end
    if (!wrap_seen) begin fails++; $display("FAIL wrap_255_to_0: got no wrap, expected 255->0"); end
    if (s_fc !== 8'd0) begin fails++; $display("FAIL wrap_final_fc: got %0d, expected 0", s_fc); end
  endtask

  initial begin
    test_reset();
    test_line_default();
    test_frame_small();
    test_pause();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
